tipi_rpi_shifter: RTL

//  Host-side master for the TIPI CPLD serial register port; it replaces RPi GPIO bit-banging.

---
 rtl/tipi_rpi_shifter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tipi_rpi_shifter.sv
// tipi_rpi_shifter: host-side serial master that reads TD/TC and writes RD/RC on the TIPI CPLD register port.
module tipi_rpi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_ctrl,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_perr,
    output logic       rsp_abort,
    output logic       r_clk,
    output logic       r_rt,
    output logic       r_cd,
    output logic       r_le,
    output logic       r_dout,
    input  logic       r_din,
    input  logic       r_reset
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, SETUP, LOAD_HI, LOAD_LO, SHIFT_HI, SHIFT_LO,
        LATCH_HI, LATCH_LO, CHECK_HI, CHECK_LO, DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [2:0]    cnt;
    logic          cnt_done;
    logic          wr;
    logic          abt;
    logic [7:0]    data;
    logic [7:0]    rx;
    logic [7:0]    rx_nxt;
    logic          phase_end;
    logic          abort_now;
    logic          finish;

    assign phase_end = div == DW'(CLK_DIV - 1);
    assign abort_now = abt | ~r_reset;
    assign finish    = abort_now || state == CHECK_LO || (state == SHIFT_LO && !wr && &cnt);

    // Shift i owns bit 7-i; writes echo the bits already sent, reads capture r_din.
    always_comb begin
        rx_nxt = rx;
        if (state == SHIFT_LO && !cnt_done) rx_nxt[~cnt] = wr ? data[~cnt] : r_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div       <= '0;
            cnt       <= '0;
            cnt_done  <= 1'b0;
            wr        <= 1'b0;
            abt       <= 1'b0;
            data      <= '0;
            rx        <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_perr  <= 1'b0;
            rsp_abort <= 1'b0;
            r_clk     <= 1'b0;
            r_rt      <= 1'b0;
            r_cd      <= 1'b1;
            r_le      <= 1'b0;
            r_dout    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    state     <= SETUP;
                    cmd_ready <= 1'b0;
                    wr        <= cmd_write;
                    data      <= cmd_data;
                    cnt       <= '0;
                    cnt_done  <= 1'b0;
                    rx        <= '0;
                    abt       <= ~r_reset;
                    r_rt      <= ~cmd_write;
                    r_cd      <= ~cmd_ctrl;
                    r_le      <= ~cmd_write;
                    r_dout    <= cmd_write & cmd_data[7];
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    r_rt      <= 1'b0;
                    r_cd      <= 1'b1;
                end
                default: begin
                    div <= phase_end ? '0 : div + 1'b1;
                    abt <= abort_now;
                    if (phase_end) begin
                        rx <= rx_nxt;
                        if (state == SHIFT_LO) begin
                            cnt_done <= &cnt;
                            cnt      <= &cnt ? cnt : cnt + 3'd1;
                        end
                        if (finish) begin
                            state     <= DONE;
                            r_clk     <= 1'b0;
                            r_le      <= 1'b0;
                            r_dout    <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rx_nxt;
                            rsp_abort <= abort_now;
                            rsp_perr  <= state == CHECK_LO && (r_din ^ ^data);
                        end else begin
                            case (state)
                                SETUP: begin
                                    state <= wr ? SHIFT_HI : LOAD_HI;
                                    r_clk <= 1'b1;
                                end
                                LOAD_HI: begin
                                    state <= LOAD_LO;
                                    r_clk <= 1'b0;
                                end
                                LOAD_LO: begin
                                    state <= SHIFT_HI;
                                    r_clk <= 1'b1;
                                    r_le  <= 1'b0;
                                end
                                SHIFT_HI: begin
                                    state  <= SHIFT_LO;
                                    r_clk  <= 1'b0;
                                    r_dout <= wr & ~&cnt & data[3'd6 - cnt];
                                end
                                SHIFT_LO: begin
                                    state <= &cnt ? LATCH_HI : SHIFT_HI;
                                    r_clk <= 1'b1;
                                    r_le  <= &cnt;
                                end
                                LATCH_HI: begin
                                    state <= LATCH_LO;
                                    r_clk <= 1'b0;
                                end
                                LATCH_LO: begin
                                    state <= CHECK_HI;
                                    r_clk <= 1'b1;
                                    r_le  <= 1'b0;
                                end
                                CHECK_HI: begin
                                    state <= CHECK_LO;
                                    r_clk <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule
